c1541_track_ctl: RTL and testbench
==================================

C1541_TRACK_CTL -- requirements
Module: c1541_track_ctl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 32000, meaning the number of clk32 cycles `track` must hold stable (1 ms) before any transfer starts.
REQ-002 SHALL have port clk32  in  1  the single clock; every register is clocked on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port img_mounted  in  1  one-cycle pulse meaning a new disk image was mounted.
REQ-005 SHALL have port track  in  6  current head track, 1-based.
REQ-006 SHALL have port gcr_we  in  1  track-buffer write strobe from the GCR datapath.
REQ-007 SHALL have port gcr_sector  in  5  sector number the GCR datapath is currently writing.
REQ-008 SHALL have port busy  out  1  high while the track buffer is not valid; the top level drives ram_ready = ~busy.
REQ-009 SHALL have port buf_sector  out  5  track-buffer sector slot targeted by the current transfer.
REQ-010 SHALL have port sd_lba  out  32  D64 256-byte block index of the current transfer.
REQ-011 SHALL have port sd_rd  out  1  block read request.
REQ-012 SHALL have port sd_wr  out  1  block write request.
REQ-013 SHALL have port sd_ack  in  1  block transfer in progress, driven by the host.

Function
REQ-014 SHALL have these states: IDLE, SETTLE, FLUSH_REQ, FLUSH_WAIT, LOAD_REQ, LOAD_WAIT, READY.
REQ-015 SHALL clamp the effective track: 0 is treated as 1, and values above 35 are treated as 35.
REQ-016 SHALL derive the sector count per track: tracks 1-17 have 21, 18-24 have 19, 25-30 have 18, 31-35 have 17.
REQ-017 SHALL compute the track base offset as (t-1)*21, 357+(t-18)*19, 490+(t-25)*18, or 598+(t-31)*17 for the four zones respectively; sd_lba = base + buf_sector, zero-extended to 32 bits.
REQ-018 SHALL move IDLE->SETTLE after reset or on img_mounted; busy=1 in every state except READY.
REQ-019 SHALL move READY->SETTLE whenever track differs from the loaded track.
REQ-020 SHALL restart the SETTLE counter whenever track changes, and leave SETTLE only after SETTLE_CYCLES consecutive stable cycles.
REQ-021 SHALL leave SETTLE for FLUSH_REQ when the dirty bitmap is non-zero, otherwise for LOAD_REQ with buf_sector=0.
REQ-022 SHALL, in FLUSH_REQ, set buf_sector to the lowest set dirty bit and use the old loaded track for sd_lba.
REQ-023 SHALL hold sd_wr (FLUSH) or sd_rd (LOAD) high until sd_ack rises, drop the request in the cycle after sd_ack is seen high, then wait in *_WAIT until sd_ack falls; the falling sd_ack completes the block.
REQ-024 SHALL clear the flushed dirty bit on FLUSH completion; when the bitmap is empty go to LOAD_REQ with buf_sector=0, otherwise return to FLUSH_REQ.
REQ-025 SHALL, on LOAD completion, increment buf_sector; after sector count-1 it records the loaded track and enters READY.
REQ-026 SHALL, on a track change during FLUSH or LOAD, finish the in-flight block and then go to SETTLE; remaining dirty bits are kept.
REQ-027 SHALL set dirty[gcr_sector] on gcr_we only in READY; gcr_we while busy is ignored.
REQ-028 SHALL, on img_mounted, clear the dirty bitmap without flushing; if a block is in flight it completes first, then SETTLE.
REQ-029 SHALL never assert sd_rd and sd_wr together.

Reset
REQ-030 SHALL, on reset, set state=IDLE, busy=1, sd_rd=0, sd_wr=0, buf_sector=0, sd_lba=0, dirty=0, loaded track invalid and settle counter=0, all asynchronously, even mid-transfer.

Structure
REQ-031 SHALL place the zone boundaries (18/25/31/36), the sectors-per-zone table and the state enum in shared package c1541_pkg.
REQ-032 SHALL implement the track-to-base/sector-count mapping as a combinational sub-module c1541_track_geom.

Verification
REQ-033 SHALL cover: reset, track=1, SETTLE_CYCLES=8 -> 21 reads with sd_lba 0..20, then busy=0.
REQ-034 SHALL cover: READY on track 18, gcr_we with sectors 3 and 7, then track=19 -> writes at lba 360 then 364, followed by reads at lba 376..394.
REQ-035 SHALL cover: track toggles 20->21->20 inside the settle window -> no sd request is issued and the settle counter restarts.
REQ-036 SHALL cover: img_mounted with dirty=0x0005 -> no sd_wr, dirty=0, and a reload of the current track.
REQ-037 SHALL cover: track=40 -> reads at lba 666..682 (17 sectors); track=0 -> reads at lba 0..20.
REQ-038 SHALL cover: reset asserted while sd_rd=1 -> sd_rd=0 in the same cycle and state=IDLE.

Source files
------------

// File: rtl/c1541_pkg.sv
// Shared definitions for the 1541 track buffer controller: D64 zone geometry
// and the controller state encoding.
package c1541_pkg;

  localparam int unsigned DIRTY_W = 21;

  // Zone k starts at ZONE_START[k]; tracks at or above TRK_END clamp to TRK_END-1.
  localparam logic [5:0] ZONE_START [4] = '{6'd1, 6'd18, 6'd25, 6'd31};
  localparam logic [5:0] TRK_END        = 6'd36;
  localparam logic [4:0] ZONE_SPT   [4] = '{5'd21, 5'd19, 5'd18, 5'd17};
  localparam logic [9:0] ZONE_BASE  [4] = '{10'd0, 10'd357, 10'd490, 10'd598};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FLUSH_REQ,
    ST_FLUSH_WAIT,
    ST_LOAD_REQ,
    ST_LOAD_WAIT,
    ST_READY
  } trk_state_t;

  function automatic logic [4:0] lowest_set(input logic [DIRTY_W-1:0] d);
    logic [4:0] idx;
    idx = '0;
    for (int unsigned i = DIRTY_W; i > 0; i--) begin
      if (d[i-1]) idx = 5'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/c1541_track_geom.sv
// Combinational D64 geometry: clamped track -> first block index and sector count.
module c1541_track_geom
  import c1541_pkg::*;
(
  input  logic [5:0] i_track,
  output logic [9:0] o_base,
  output logic [4:0] o_nsect
);

  logic [5:0] w_trk;
  logic [5:0] w_rel;
  logic [1:0] w_zone;

  always_comb begin
    w_trk = i_track;
    if (i_track == '0)
      w_trk = 6'd1;
    else if (i_track >= TRK_END)
      w_trk = TRK_END - 6'd1;

    w_zone = '0;
    for (int unsigned z = 1; z < 4; z++) begin
      if (w_trk >= ZONE_START[z]) w_zone = 2'(z);
    end

    w_rel   = w_trk - ZONE_START[w_zone];
    o_nsect = ZONE_SPT[w_zone];
    o_base  = ZONE_BASE[w_zone] + 10'(w_rel) * 10'(ZONE_SPT[w_zone]);
  end

endmodule

// File: rtl/c1541_track_ctl.sv
// Track buffer controller: waits for the head to settle, flushes dirty sectors
// of the old track, then loads every sector of the new track from the D64 image.
module c1541_track_ctl
  import c1541_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 32000
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [5:0]  track,
  input  logic        gcr_we,
  input  logic [4:0]  gcr_sector,
  output logic        busy,
  output logic [4:0]  buf_sector,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack
);

  trk_state_t         r_state;
  logic [DIRTY_W-1:0] r_dirty;
  logic [5:0]         r_loaded_trk;
  logic [5:0]         r_target_trk;
  logic [5:0]         r_prev_trk;
  logic               r_loaded_vld;
  logic               r_resettle;
  logic [31:0]        r_settle_cnt;
  logic [4:0]         r_buf_sector;
  logic               r_sd_rd;
  logic               r_sd_wr;

  logic [5:0]         w_geom_trk;
  logic [9:0]         w_base;
  logic [4:0]         w_nsect;
  logic               w_flushing;
  logic               w_in_xfer;
  logic               w_trk_chg;
  logic               w_resettle;
  logic [DIRTY_W-1:0] w_dirty_left;

  // Flushes address the track the buffer still holds; loads address the new one.
  assign w_flushing = (r_state == ST_FLUSH_REQ) || (r_state == ST_FLUSH_WAIT);
  assign w_in_xfer  = w_flushing || (r_state == ST_LOAD_REQ) || (r_state == ST_LOAD_WAIT);
  assign w_geom_trk = w_flushing ? r_loaded_trk : r_target_trk;

  c1541_track_geom u_geom (
    .i_track (w_geom_trk),
    .o_base  (w_base),
    .o_nsect (w_nsect)
  );

  assign w_trk_chg    = (track != r_prev_trk);
  assign w_resettle   = r_resettle || w_trk_chg || img_mounted;
  assign w_dirty_left = r_dirty & ~(DIRTY_W'(1) << r_buf_sector);

  assign busy       = (r_state != ST_READY);
  assign buf_sector = r_buf_sector;
  assign sd_lba     = {22'd0, w_base + 10'(r_buf_sector)};
  assign sd_rd      = r_sd_rd;
  assign sd_wr      = r_sd_wr;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_dirty      <= '0;
      r_loaded_trk <= '0;
      r_target_trk <= '0;
      r_prev_trk   <= '0;
      r_loaded_vld <= 1'b0;
      r_resettle   <= 1'b0;
      r_settle_cnt <= '0;
      r_buf_sector <= '0;
      r_sd_rd      <= 1'b0;
      r_sd_wr      <= 1'b0;
    end else begin
      r_prev_trk <= track;
      if (w_in_xfer && (w_trk_chg || img_mounted)) r_resettle <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_state      <= ST_SETTLE;
          r_settle_cnt <= '0;
        end

        ST_SETTLE: begin
          if (img_mounted || w_trk_chg) begin
            r_settle_cnt <= '0;
          end else if (r_settle_cnt >= 32'(SETTLE_CYCLES - 1)) begin
            r_settle_cnt <= '0;
            r_target_trk <= track;
            if (r_dirty != '0) begin
              r_state      <= ST_FLUSH_REQ;
              r_buf_sector <= lowest_set(r_dirty);
              r_sd_wr      <= 1'b1;
            end else begin
              r_state      <= ST_LOAD_REQ;
              r_buf_sector <= '0;
              r_loaded_vld <= 1'b0;
              r_sd_rd      <= 1'b1;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + 32'd1;
          end
        end

        ST_FLUSH_REQ: begin
          if (sd_ack) begin
            r_sd_wr <= 1'b0;
            r_state <= ST_FLUSH_WAIT;
          end
        end

        ST_FLUSH_WAIT: begin
          if (!sd_ack) begin
            r_dirty    <= w_dirty_left;
            r_resettle <= 1'b0;
            if (w_resettle) begin
              r_state      <= ST_SETTLE;
              r_settle_cnt <= '0;
            end else if (w_dirty_left == '0) begin
              r_state      <= ST_LOAD_REQ;
              r_buf_sector <= '0;
              r_loaded_vld <= 1'b0;
              r_sd_rd      <= 1'b1;
            end else begin
              r_state      <= ST_FLUSH_REQ;
              r_buf_sector <= lowest_set(w_dirty_left);
              r_sd_wr      <= 1'b1;
            end
          end
        end

        ST_LOAD_REQ: begin
          if (sd_ack) begin
            r_sd_rd <= 1'b0;
            r_state <= ST_LOAD_WAIT;
          end
        end

        ST_LOAD_WAIT: begin
          if (!sd_ack) begin
            r_resettle <= 1'b0;
            if (w_resettle) begin
              r_state      <= ST_SETTLE;
              r_settle_cnt <= '0;
            end else if (r_buf_sector == w_nsect - 5'd1) begin
              r_state      <= ST_READY;
              r_loaded_trk <= r_target_trk;
              r_loaded_vld <= 1'b1;
            end else begin
              r_state      <= ST_LOAD_REQ;
              r_buf_sector <= r_buf_sector + 5'd1;
              r_sd_rd      <= 1'b1;
            end
          end
        end

        ST_READY: begin
          if (img_mounted || !r_loaded_vld || (track != r_loaded_trk)) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
          end else if (gcr_we && (gcr_sector < w_nsect)) begin
            r_dirty[gcr_sector] <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase

      // A new image invalidates all pending writes, whatever the state.
      if (img_mounted) r_dirty <= '0;
    end
  end

endmodule

// File: tb/tb_c1541_track_ctl.sv
// Directed bench for c1541_track_ctl with a simple host model answering sd_rd/sd_wr.
module tb_c1541_track_ctl;

  logic        clk32 = 1'b0;
  logic        reset;
  logic        img_mounted;
  logic [5:0]  track;
  logic        gcr_we;
  logic [4:0]  gcr_sector;
  logic        busy;
  logic [4:0]  buf_sector;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  int n_vec = 0;
  int n_err = 0;

  c1541_track_ctl #(.SETTLE_CYCLES(8)) dut (
    .clk32       (clk32),
    .reset       (reset),
    .img_mounted (img_mounted),
    .track       (track),
    .gcr_we      (gcr_we),
    .gcr_sector  (gcr_sector),
    .busy        (busy),
    .buf_sector  (buf_sector),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack)
  );

  always #5 clk32 = ~clk32;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for a request, checks its kind and block index, then runs the ack handshake.
  task automatic serve(input string tag, input bit exp_wr, input logic [31:0] exp_lba);
    int n;
    n = 0;
    while (!(sd_rd || sd_wr) && n < 200) begin
      @(negedge clk32);
      n++;
    end
    chk({tag, "_kind"}, {30'd0, sd_wr, sd_rd}, exp_wr ? 32'd2 : 32'd1);
    chk({tag, "_lba"}, sd_lba, exp_lba);
    sd_ack = 1'b1;
    n = 0;
    do begin
      @(negedge clk32);
      n++;
    end while ((sd_rd || sd_wr) && n < 10);
    chk({tag, "_drop"}, {31'd0, sd_rd | sd_wr}, 32'd0);
    @(negedge clk32);
    sd_ack = 1'b0;
  endtask

  task automatic pulse_we(input logic [4:0] sec);
    gcr_we     = 1'b1;
    gcr_sector = sec;
    @(negedge clk32);
    gcr_we     = 1'b0;
  endtask

  task automatic expect_ready(input string tag);
    @(negedge clk32);
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    img_mounted = 1'b0;
    track       = 6'd1;
    gcr_we      = 1'b0;
    gcr_sector  = '0;
    sd_ack      = 1'b0;
    repeat (2) @(negedge clk32);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rd", {31'd0, sd_rd}, 32'd0);
    chk("rst_wr", {31'd0, sd_wr}, 32'd0);
    chk("rst_buf", {27'd0, buf_sector}, 32'd0);
    chk("rst_lba", sd_lba, 32'd0);
    reset = 1'b0;

    // Track 1: 21 blocks at 0..20
    for (int i = 0; i < 21; i++) serve("t1_rd", 1'b0, 32'(i));
    expect_ready("t1_ready");

    // Toggle 20->21->20 inside the settle window, then exactly 9 edges to the request
    track = 6'd20;
    repeat (5) @(negedge clk32);
    chk("tog_a_noreq", {31'd0, sd_rd | sd_wr}, 32'd0);
    track = 6'd21;
    repeat (5) @(negedge clk32);
    chk("tog_b_noreq", {31'd0, sd_rd | sd_wr}, 32'd0);
    track = 6'd20;
    repeat (8) @(negedge clk32);
    chk("tog_c_noreq", {31'd0, sd_rd | sd_wr}, 32'd0);
    chk("tog_c_busy", {31'd0, busy}, 32'd1);
    @(negedge clk32);
    chk("tog_c_req", {31'd0, sd_rd}, 32'd1);
    for (int i = 0; i < 19; i++) serve("t20_rd", 1'b0, 32'(395 + i));
    expect_ready("t20_ready");

    // Track 18, dirty sectors 3 and 7, move to 19: flush then reload
    track = 6'd18;
    for (int i = 0; i < 19; i++) serve("t18_rd", 1'b0, 32'(357 + i));
    expect_ready("t18_ready");
    pulse_we(5'd3);
    pulse_we(5'd7);
    track = 6'd19;
    serve("t18_wr3", 1'b1, 32'd360);
    serve("t18_wr7", 1'b1, 32'd364);
    for (int i = 0; i < 19; i++) serve("t19_rd", 1'b0, 32'(376 + i));
    expect_ready("t19_ready");

    // Mount with dirty=0x0005: no writes, reload; a write while busy is dropped
    pulse_we(5'd0);
    pulse_we(5'd2);
    img_mounted = 1'b1;
    @(negedge clk32);
    img_mounted = 1'b0;
    pulse_we(5'd1);
    for (int i = 0; i < 19; i++) serve("mnt_rd", 1'b0, 32'(376 + i));
    expect_ready("mnt_ready");
    track = 6'd20;
    for (int i = 0; i < 19; i++) serve("mnt_t20_rd", 1'b0, 32'(395 + i));
    expect_ready("mnt_t20_ready");

    // Clamping: 40 behaves as 35, 0 as 1
    track = 6'd40;
    for (int i = 0; i < 17; i++) serve("t40_rd", 1'b0, 32'(666 + i));
    expect_ready("t40_ready");
    track = 6'd0;
    for (int i = 0; i < 21; i++) serve("t0_rd", 1'b0, 32'(i));
    expect_ready("t0_ready");

    // Asynchronous reset while a read request is pending
    track = 6'd5;
    begin
      int n;
      n = 0;
      while (!sd_rd && n < 200) begin
        @(negedge clk32);
        n++;
      end
    end
    chk("pre_rst_rd", {31'd0, sd_rd}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_rd", {31'd0, sd_rd}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd1);
    chk("async_rst_buf", {27'd0, buf_sector}, 32'd0);
    @(negedge clk32);
    chk("async_rst_wr", {31'd0, sd_wr}, 32'd0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
